// File: rtl/falling_edge_positive_one_shot.sv
// falling_edge_positive_one_shot
// Turns each high-to-low transition of InputPulse, sampled on the rising edge
// of CLOCK, into a single-cycle active-high OneShot pulse. Moore FSM with a
// 2-bit binary state register; OneShot is decoded from state only.
// Optional build macro: FEPOS_SYNC_EN adds a two-flop input synchronizer
// (2 cycles of extra latency) for inputs asynchronous to CLOCK.
module falling_edge_positive_one_shot (
  input  logic Reset,
  input  logic CLOCK,
  input  logic InputPulse,
  output logic OneShot
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'b00,
    ARMED     = 2'b01,
    PULSE     = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_sample;

`ifdef FEPOS_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer; cleared by reset so a low input never looks armed
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= InputPulse;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = InputPulse;
`endif

  // State register; reset forces WAIT_HIGH immediately
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      r_state <= WAIT_HIGH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the unused code falls back to WAIT_HIGH
  always_comb begin
    w_next = WAIT_HIGH;
    case (r_state)
      WAIT_HIGH: w_next = w_sample ? ARMED : WAIT_HIGH;
      ARMED:     w_next = w_sample ? ARMED : PULSE;
      PULSE:     w_next = w_sample ? ARMED : WAIT_HIGH;
      default:   w_next = WAIT_HIGH;
    endcase
  end

  assign OneShot = (r_state == PULSE);

endmodule

// File: tb/tb_falling_edge_positive_one_shot.sv
// Testbench for falling_edge_positive_one_shot.
// A behavioural edge-detect model pushes the expected OneShot value for the
// next rising edge into a queue when the input is driven; the value is popped
// and compared 1 ns after that edge.
module tb_falling_edge_positive_one_shot;

  logic Reset;
  logic CLOCK;
  logic InputPulse;
  logic OneShot;

  int unsigned n_tests;
  int unsigned n_fail;

  logic q_exp[$];
  logic m_armed;
  logic m_s1;
  logic m_s2;
  logic last_exp;
  int unsigned pulse_cnt;

  falling_edge_positive_one_shot dut (
    .Reset      (Reset),
    .CLOCK      (CLOCK),
    .InputPulse (InputPulse),
    .OneShot    (OneShot)
  );

  initial begin
    CLOCK = 1'b0;
    #5;
    forever begin
      CLOCK = 1'b1;
      #5;
      CLOCK = 1'b0;
      #5;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    m_armed = 1'b0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
    q_exp.delete();
  endtask

  // Predict OneShot after the next rising edge for input level v
  task automatic model_step(input logic v);
    logic w;
    logic e;
`ifdef FEPOS_SYNC_EN
    w    = m_s2;
    m_s2 = m_s1;
    m_s1 = v;
`else
    w = v;
`endif
    e = !w && m_armed;
    if (w) m_armed = 1'b1;
    else if (e) m_armed = 1'b0;
    q_exp.push_back(e);
  endtask

  task automatic sample(input string tag);
    logic e;
    @(posedge CLOCK);
    #1;
    check_eq("sb_nonempty", q_exp.size() != 0, 1'b1);
    e = 1'b0;
    if (q_exp.size() != 0) e = q_exp.pop_front();
    last_exp = e;
    if (OneShot === 1'b1) pulse_cnt++;
    check_eq(tag, OneShot, e);
  endtask

  task automatic do_cycle(input string tag, input logic v);
    @(negedge CLOCK);
    InputPulse = v;
    model_step(v);
    sample(tag);
  endtask

  // Glitch cycle: level v at the edge, opposite level for 3 ns between edges
  task automatic glitch_cycle(input string tag, input logic v);
    @(negedge CLOCK);
    InputPulse = v;
    model_step(v);
    sample(tag);
    #1;
    InputPulse = !v;
    #3;
    InputPulse = v;
  endtask

  // Hold reset for a few edges with input v, then release 3 ns after a fall
  task automatic do_reset(input logic v);
    Reset      = 1'b0;
    InputPulse = v;
    model_clear();
    repeat (3) begin
      @(posedge CLOCK);
      #1;
      check_eq("reset_hold", OneShot, 1'b0);
    end
    @(negedge CLOCK);
    #3;
    Reset = 1'b1;
    model_step(v);
    sample("reset_first_edge");
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    last_exp   = 1'b0;
    pulse_cnt  = 0;
    Reset      = 1'b0;
    InputPulse = 1'b1;
    model_clear();
    #1;
    check_eq("reset_async_t0", OneShot, 1'b0);

    // Reset with input high, then a single fall
    do_reset(1'b1);
    repeat (2) do_cycle("single_high", 1'b1);
    pulse_cnt = 0;
    repeat (6) do_cycle("single_fall", 1'b0);
    check_eq("single_one_pulse", pulse_cnt == 1, 1'b1);

    // Held high: no pulses; held low 40 cycles after one fall: one pulse
    pulse_cnt = 0;
    repeat (8) do_cycle("held_high", 1'b1);
    check_eq("held_high_none", pulse_cnt == 0, 1'b1);
    pulse_cnt = 0;
    repeat (40) do_cycle("held_low", 1'b0);
    check_eq("held_low_one", pulse_cnt == 1, 1'b1);

    // Input low at reset release: no pulse until seen high then low
    do_reset(1'b0);
    pulse_cnt = 0;
    repeat (4) do_cycle("low_rel_low", 1'b0);
    check_eq("low_rel_none", pulse_cnt == 0, 1'b1);
    repeat (2) do_cycle("low_rel_high", 1'b1);
    repeat (5) do_cycle("low_rel_fall", 1'b0);
    check_eq("low_rel_one", pulse_cnt == 1, 1'b1);

    // Rapid toggle 1,0,1,0 on consecutive edges: two pulses
    repeat (2) do_cycle("toggle_pre", 1'b1);
    pulse_cnt = 0;
    do_cycle("toggle_0", 1'b0);
    do_cycle("toggle_1", 1'b1);
    do_cycle("toggle_2", 1'b0);
    repeat (4) do_cycle("toggle_tail", 1'b0);
    check_eq("toggle_two", pulse_cnt == 2, 1'b1);

    // 3 ns high glitch between edges while low: no pulse
    pulse_cnt = 0;
    repeat (3) glitch_cycle("glitch", 1'b0);
    repeat (3) do_cycle("glitch_tail", 1'b0);
    check_eq("glitch_none", pulse_cnt == 0, 1'b1);

    // Async reset mid-pulse
    repeat (3) do_cycle("mid_high", 1'b1);
    last_exp = 1'b0;
    for (int unsigned i = 0; i < 6 && !last_exp; i++) do_cycle("mid_fall", 1'b0);
    check_eq("mid_pulse_seen", OneShot, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("mid_async_clear", OneShot, 1'b0);
    do_reset(1'b0);
    pulse_cnt = 0;
    repeat (6) do_cycle("mid_after", 1'b0);
    check_eq("mid_after_none", pulse_cnt == 0, 1'b1);

    // Randomised level stream, each level held for a whole period
    for (int unsigned i = 0; i < 300; i++) begin
      do_cycle("random", 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/falling_edge_positive_one_shot.md
# falling_edge_positive_one_shot

Synchronous falling-edge detector that converts a level input (e.g. a debounced push-button or paddle control line) into a single-clock-wide, active-high pulse. Each high-to-low transition of `InputPulse`, as sampled on the rising edge of `CLOCK`, produces exactly one `OneShot` pulse. It sits between input conditioning and game-control logic so that downstream FSMs see one event per press or release.

## Interface
- No parameters.
- `CLOCK`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-low reset.
- `InputPulse`  input  1  level input to monitor; may be asynchronous to `CLOCK` when the synchronizer is compiled in.
- `OneShot`  output  1  registered, active-high, one-cycle pulse per detected falling edge.
- Port order: `Reset`, `CLOCK`, `InputPulse`, `OneShot`.

## Operation
- Moore FSM with three states, binary-encoded in a 2-bit state register. The unused code recovers to `WAIT_HIGH`.
- `WAIT_HIGH`: reset state; waiting for the input to be high.
  - Sampled input = 1 -> `ARMED`.
  - Otherwise stay.
- `ARMED`: input seen high.
  - Sampled input = 0 -> `PULSE`.
  - Otherwise stay.
- `PULSE`: `OneShot` = 1.
  - Sampled input = 1 -> `ARMED`. A re-rise within one cycle re-arms the FSM, so the next fall pulses again.
  - Otherwise -> `WAIT_HIGH`.
- `OneShot` = 1 only in `PULSE`. It is decoded from the state register and has no combinational path from `InputPulse`.
- Holding the input low for any length of time produces exactly one pulse. Holding it high produces none.
- Leaving reset with the input low produces no pulse until the input has been sampled high and then low.
- Asserting `Reset` (0) at any time, including mid-pulse, immediately forces state = `WAIT_HIGH` and `OneShot` = 0, independent of `CLOCK`.
- Reset release is synchronous in effect: the first state update happens on the first rising edge after `Reset` = 1.

## Timing
- Reset value: `OneShot` = 0, state = `WAIT_HIGH`, synchronizer flops (if present) = 0.
- Without the synchronizer:
  - The input is sampled directly on each rising edge.
  - `OneShot` rises on the first rising edge that samples 0 after a sampled 1.
  - `OneShot` stays high for exactly one clock period.
- With the synchronizer: add exactly 2 cycles of latency. Pulse width is still one period.
- Input levels shorter than one clock period may be missed. Guaranteed detection requires each level to be stable for at least one full period, plus setup/hold time around the sampling edge.
- Minimum spacing between consecutive pulses is 2 cycles (fall, rise, fall on three consecutive edges).

## Configuration
- `FEPOS_SYNC_EN`
  - Defined: `InputPulse` passes through a two-flop synchronizer (reset to 0 by `Reset`) before the FSM. Latency is 2 cycles larger than without it.
  - Undefined: the FSM samples `InputPulse` directly. This mode is for inputs already synchronous to `CLOCK`.

## Test plan
Common setup: clock period 10 ns, first rising edge at 5 ns. Timings below are for `FEPOS_SYNC_EN` undefined unless noted.
- **Reset:** `Reset` = 0 from 0–13 ns with `InputPulse` = 1 -> `OneShot` = 0 throughout reset; no pulse at the edge at 15 ns.
- **Single fall:** `InputPulse` = 1 from 0 ns, falls at 32 ns -> `OneShot` = 1 exactly 35–45 ns. With `FEPOS_SYNC_EN` defined, `OneShot` = 1 exactly 55–65 ns.
- **Held low:** `InputPulse` low for 40 cycles after one fall -> exactly one 10 ns pulse.
- **Low at reset release:** `InputPulse` = 0 when `Reset` rises at 13 ns, rises at 52 ns, falls at 72 ns -> only pulse at 75–85 ns.
- **Async reset mid-pulse:** `Reset` driven to 0 at 38 ns during the 35–45 ns pulse -> `OneShot` = 0 at 38 ns without waiting for a clock edge; no pulse after release while the input stays low.
- **Rapid toggle and glitch:**
  - `InputPulse` sampled 1, 0, 1, 0 on four consecutive edges -> two one-cycle pulses.
  - A 3 ns high glitch between edges -> no pulse.
